stage_sequencer: RTL

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer_pkg.sv | 31 +++
 rtl/stage_sequencer_timer.sv | 27 ++
 rtl/stage_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the instruction stage sequencer: decoder mode codes,
// state encoding and latency clamping.
package stage_sequencer_pkg;

  localparam int CNT_W = 8;

  localparam logic [3:0] MODE_MUL      = 4'd1;
  localparam logic [3:0] MODE_MLA      = 4'd2;
  localparam logic [3:0] MODE_UMULL    = 4'd3;
  localparam logic [3:0] MODE_SMULL    = 4'd4;
  localparam logic [3:0] MODE_SKIP_ALU = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPREAD = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_WB2    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // A zero latency would never expire; clamp into the counter's 1..max range.
  function automatic logic [CNT_W-1:0] eff_lat(input int unsigned lat);
    if (lat == 0) return CNT_W'(1);
    else if (lat > 255) return '1;
    else return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/stage_sequencer_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded interval.
module stage_timer
  import stage_sequencer_pkg::*;
(
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/stage_sequencer.sv
// Fetch/decode/operand-read/execute/writeback sequencer driving datapath
// enables; EXEC length comes from the captured multiplier/ALU hot flags.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | operand bank active, waiting for mem_ready
// DECODE | decoder active for one cycle
// OPREAD | register bank read, decoder outputs captured on exit
// EXEC   | multiplier settle and/or ALU phase, timed by stage_timer
// WB     | first destination write, flags write
// WB2    | second destination (RdLo) write for long multiplies
// HALT   | zero instruction fetched, only reset leaves
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned ALU_LAT = 4,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] instr,
  input  logic [3:0]  dec_mode,
  input  logic        dec_mult_hot,
  input  logic        dec_alu_hot,
  input  logic        dec_reg_w,
  input  logic        dec_S,
  output logic        pc_increment,
  output logic        ir_load,
  output logic        decoder_active,
  output logic        regbank_active,
  output logic        mult_load,
  output logic        alu_active,
  output logic        reg_w,
  output logic        wb_sel,
  output logic        cpsr_w,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  state
);

  localparam logic [CNT_W-1:0] ALU_L = eff_lat(ALU_LAT);
  localparam logic [CNT_W-1:0] MUL_L = eff_lat(MUL_LAT);

  state_t           st;
  logic [3:0]       cap_mode;
  logic             cap_mult, cap_alu, cap_reg_w, cap_s;
  logic             alu_phase;
  logic             tmr_done, tmr_load, mla_turn;
  logic [CNT_W-1:0] first_lat, tmr_val;

  // MLA: multiplier interval expired, reload the timer for the ALU interval.
  assign mla_turn  = (st == S_EXEC) && tmr_done && !alu_phase && cap_mult && cap_alu;
  assign first_lat = dec_mult_hot ? MUL_L : (dec_alu_hot ? ALU_L : CNT_W'(1));
  assign tmr_load  = (st == S_OPREAD) || mla_turn;
  assign tmr_val   = (st == S_OPREAD) ? first_lat : ALU_L;

  stage_timer u_timer (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (st == S_EXEC),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign ir_load      = (st == S_FETCH) && mem_ready;
  assign pc_increment = ir_load;
  assign state        = st;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      st             <= S_IDLE;
      cap_mode       <= '0;
      cap_mult       <= 1'b0;
      cap_alu        <= 1'b0;
      cap_reg_w      <= 1'b0;
      cap_s          <= 1'b0;
      alu_phase      <= 1'b0;
      decoder_active <= 1'b0;
      regbank_active <= 1'b0;
      mult_load      <= 1'b0;
      alu_active     <= 1'b0;
      reg_w          <= 1'b0;
      wb_sel         <= 1'b0;
      cpsr_w         <= 1'b0;
      busy           <= 1'b0;
      halted         <= 1'b0;
    end else begin
      decoder_active <= 1'b0;
      regbank_active <= 1'b0;
      mult_load      <= 1'b0;
      alu_active     <= 1'b0;
      reg_w          <= 1'b0;
      wb_sel         <= 1'b0;
      cpsr_w         <= 1'b0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            st             <= S_FETCH;
            regbank_active <= 1'b1;
            busy           <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!mem_ready) begin
            regbank_active <= 1'b1;
            busy           <= 1'b1;
          end else if (instr == 32'h0) begin
            st     <= S_HALT;
            halted <= 1'b1;
          end else begin
            st             <= S_DECODE;
            decoder_active <= 1'b1;
            busy           <= 1'b1;
          end
        end
        S_DECODE: begin
          st             <= S_OPREAD;
          regbank_active <= 1'b1;
          busy           <= 1'b1;
        end
        S_OPREAD: begin
          st         <= S_EXEC;
          cap_mode   <= dec_mode;
          cap_mult   <= dec_mult_hot;
          cap_alu    <= dec_alu_hot;
          cap_reg_w  <= dec_reg_w;
          cap_s      <= dec_S;
          alu_phase  <= !dec_mult_hot && dec_alu_hot;
          alu_active <= !dec_mult_hot && dec_alu_hot;
          mult_load  <= dec_mult_hot;
          busy       <= 1'b1;
        end
        S_EXEC: begin
          busy <= 1'b1;
          if (mla_turn) begin
            alu_phase  <= 1'b1;
            alu_active <= 1'b1;
          end else if (tmr_done) begin
            st     <= S_WB;
            reg_w  <= cap_reg_w;
            cpsr_w <= cap_s;
          end else begin
            alu_active <= alu_phase;
          end
        end
        S_WB: begin
          busy <= 1'b1;
          if ((cap_mode == MODE_UMULL || cap_mode == MODE_SMULL) && cap_reg_w) begin
            st     <= S_WB2;
            reg_w  <= 1'b1;
            wb_sel <= 1'b1;
          end else begin
            st             <= S_FETCH;
            regbank_active <= 1'b1;
          end
        end
        S_WB2: begin
          st             <= S_FETCH;
          regbank_active <= 1'b1;
          busy           <= 1'b1;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
